// File: rtl/mem_arbiter_pkg.sv
// Shared grant-state encodings and boolean constants for the memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GNT_IF = 2'd1,
      ARB_GNT_LD = 2'd2,
      ARB_GNT_ST = 2'd3
   } arb_state_e;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   // Wide enough for any starvation limit in 1..15
   localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating starvation counter: clr wins over inc, holds at LIMIT, frozen when en=0.
// Registered count; at_limit is decoded from the flop, so it is visible the cycle after the update.
module arb_starve_counter #(
   parameter int LIMIT = 4,
   parameter int W     = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         if (clr)
            cnt_d = '0;
         else if (inc && (cnt_q != LIM))
            cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/LSB arbiter onto a single memory port: grant one cycle after a request seen in IDLE, ack one cycle after mc_done.
// Backpressure: rdy=0 freezes everything; requesters hold req until ack, and the grant is held until mc_done or abort.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              flush,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   input  logic              lsb_req,
   input  logic              lsb_wr,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [31:0]       lsb_wdata,
   output logic              lsb_ack,
   output logic [31:0]       lsb_rdata,
   output logic              mc_valid,
   output logic              mc_wr,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [31:0]       mc_wdata,
   input  logic              mc_done,
   input  logic [31:0]       mc_rdata
);

   arb_state_e        state_q, state_d;
   logic              mc_valid_q, mc_valid_d;
   logic              mc_wr_q, mc_wr_d;
   logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
   logic [31:0]       mc_wdata_q, mc_wdata_d;
   logic              if_ack_q, if_ack_d;
   logic              lsb_ack_q, lsb_ack_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       lsb_rdata_q, lsb_rdata_d;
   logic              cnt_inc, cnt_clr, starve_hit;
   logic              lsb_wins;

   arb_starve_counter #(
      .LIMIT (STARVE_LIMIT),
      .W     (STARVE_W)
   ) u_starve (
      .clk      (clk),
      .rst      (rst),
      .en       (rdy),
      .inc      (cnt_inc),
      .clr      (cnt_clr),
      .at_limit (starve_hit)
   );

   assign lsb_wins = lsb_req && (!if_req || starve_hit);

   always_comb begin
      state_d     = state_q;
      mc_valid_d  = mc_valid_q;
      mc_wr_d     = mc_wr_q;
      mc_addr_d   = mc_addr_q;
      mc_wdata_d  = mc_wdata_q;
      if_ack_d    = FALSE;
      lsb_ack_d   = FALSE;
      if_rdata_d  = if_rdata_q;
      lsb_rdata_d = lsb_rdata_q;
      cnt_inc     = FALSE;
      cnt_clr     = FALSE;

      if (rdy) begin
         case (state_q)
            ARB_IDLE: begin
               // Flush blocks speculative (fetch/load) grants; a store is architectural and may still go.
               if (lsb_wins && (lsb_wr || !flush)) begin
                  state_d    = lsb_wr ? ARB_GNT_ST : ARB_GNT_LD;
                  mc_valid_d = TRUE;
                  mc_wr_d    = lsb_wr;
                  mc_addr_d  = lsb_addr;
                  mc_wdata_d = lsb_wdata;
                  cnt_clr    = TRUE;
               end else if (!lsb_wins && if_req && !flush) begin
                  state_d    = ARB_GNT_IF;
                  mc_valid_d = TRUE;
                  mc_wr_d    = FALSE;
                  mc_addr_d  = if_addr;
                  cnt_inc    = lsb_req;
                  cnt_clr    = !lsb_req;
               end
            end
            ARB_GNT_IF: begin
               if (flush || !if_req) begin
                  state_d    = ARB_IDLE;
                  mc_valid_d = FALSE;
               end else if (mc_done) begin
                  state_d    = ARB_IDLE;
                  mc_valid_d = FALSE;
                  if_ack_d   = TRUE;
                  if_rdata_d = mc_rdata;
               end
            end
            ARB_GNT_LD: begin
               if (flush || !lsb_req) begin
                  state_d    = ARB_IDLE;
                  mc_valid_d = FALSE;
               end else if (mc_done) begin
                  state_d     = ARB_IDLE;
                  mc_valid_d  = FALSE;
                  lsb_ack_d   = TRUE;
                  lsb_rdata_d = mc_rdata;
               end
            end
            ARB_GNT_ST: begin
               if (mc_done) begin
                  state_d    = ARB_IDLE;
                  mc_valid_d = FALSE;
                  mc_wr_d    = FALSE;
                  lsb_ack_d  = TRUE;
               end
            end
            default: state_d = ARB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         mc_valid_q  <= FALSE;
         mc_wr_q     <= FALSE;
         mc_addr_q   <= '0;
         mc_wdata_q  <= '0;
         if_ack_q    <= FALSE;
         lsb_ack_q   <= FALSE;
         if_rdata_q  <= '0;
         lsb_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mc_valid_q  <= mc_valid_d;
         mc_wr_q     <= mc_wr_d;
         mc_addr_q   <= mc_addr_d;
         mc_wdata_q  <= mc_wdata_d;
         if_ack_q    <= if_ack_d;
         lsb_ack_q   <= lsb_ack_d;
         if_rdata_q  <= if_rdata_d;
         lsb_rdata_q <= lsb_rdata_d;
      end
   end

   assign mc_valid  = mc_valid_q;
   assign mc_wr     = mc_wr_q;
   assign mc_addr   = mc_addr_q;
   assign mc_wdata  = mc_wdata_q;
   assign if_ack    = if_ack_q;
   assign lsb_ack   = lsb_ack_q;
   assign if_rdata  = if_rdata_q;
   assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level owner/streak model checked every negedge.
module tb_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst, rdy, flush;
   logic        if_req, lsb_req, lsb_wr, mc_done;
   logic [31:0] if_addr, lsb_addr, lsb_wdata, mc_rdata;
   logic        if_ack, lsb_ack, mc_valid, mc_wr;
   logic [31:0] if_rdata, lsb_rdata, mc_addr, mc_wdata;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
      .lsb_ack(lsb_ack), .lsb_rdata(lsb_rdata),
      .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
      .mc_done(mc_done), .mc_rdata(mc_rdata)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tmo(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got no event want event within bound (t=%0t)", nm, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {OWN_NONE, OWN_IF, OWN_LD, OWN_ST} own_e;
   own_e        owner;
   int          streak;
   logic        e_valid, e_wr, e_if_ack, e_lsb_ack;
   logic [31:0] e_addr, e_wdata, e_if_rdata, e_lsb_rdata;

   task automatic model_reset();
      owner = OWN_NONE; streak = 0;
      e_valid = 0; e_wr = 0; e_if_ack = 0; e_lsb_ack = 0;
      e_addr = 0; e_wdata = 0; e_if_rdata = 0; e_lsb_rdata = 0;
   endtask

   // Predict what the outputs look like after the next clock edge.
   task automatic model_step();
      bit lsb_first;
      e_if_ack  = 0;
      e_lsb_ack = 0;
      if (!rdy) return;
      if (owner == OWN_NONE) begin
         lsb_first = lsb_req && (!if_req || streak == LIMIT);
         if (lsb_first && (lsb_wr || !flush)) begin
            owner   = lsb_wr ? OWN_ST : OWN_LD;
            e_valid = 1; e_wr = lsb_wr; e_addr = lsb_addr; e_wdata = lsb_wdata;
            streak  = 0;
         end else if (!lsb_first && if_req && !flush) begin
            owner   = OWN_IF;
            e_valid = 1; e_wr = 0; e_addr = if_addr;
            streak  = lsb_req ? ((streak + 1 > LIMIT) ? LIMIT : streak + 1) : 0;
         end
      end else if (owner == OWN_ST) begin
         if (mc_done) begin
            owner = OWN_NONE; e_valid = 0; e_wr = 0; e_lsb_ack = 1;
         end
      end else begin
         if (flush || !(owner == OWN_IF ? if_req : lsb_req)) begin
            owner = OWN_NONE; e_valid = 0;
         end else if (mc_done) begin
            if (owner == OWN_IF) begin e_if_ack = 1; e_if_rdata = mc_rdata; end
            else begin e_lsb_ack = 1; e_lsb_rdata = mc_rdata; end
            owner = OWN_NONE; e_valid = 0;
         end
      end
   endtask

   logic [31:0] grant_log[$];
   logic        prev_valid = 1'b0;

   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (rst) model_reset();
         chk1("mc_valid", mc_valid, e_valid);
         chk1("mc_wr", mc_wr, e_wr);
         chk1("if_ack", if_ack, e_if_ack);
         chk1("lsb_ack", lsb_ack, e_lsb_ack);
         chk("mc_addr", mc_addr, e_addr);
         chk("mc_wdata", mc_wdata, e_wdata);
         chk("if_rdata", if_rdata, e_if_rdata);
         chk("lsb_rdata", lsb_rdata, e_lsb_rdata);
         if (mc_valid && !prev_valid) grant_log.push_back(mc_addr);
         prev_valid = mc_valid;
         if (!rst) model_step();
      end
   end

   // ---------------- downstream responder ----------------
   logic        resp_en, man_done;
   logic [31:0] man_rdata;
   int          resp_lat;

   function automatic logic [31:0] resp_data(input logic [31:0] a);
      return (a == 32'h1000) ? 32'hDEADBEEF : (a ^ 32'h5A00_0000);
   endfunction

   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!resp_en) begin
            mc_done = man_done; mc_rdata = man_rdata; cnt = 0;
         end else if (mc_valid && rdy && !mc_done) begin
            cnt++;
            if (cnt >= resp_lat) begin
               mc_done = 1; mc_rdata = resp_data(mc_addr); cnt = 0;
            end
         end else begin
            mc_done = 0; cnt = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string nm);
      for (int i = 0; i < 50; i++) begin
         if (mc_valid) return;
         step();
      end
      tmo(nm);
   endtask

   task automatic wait_lsb_ack(input string nm);
      for (int i = 0; i < 50; i++) begin
         step();
         if (lsb_ack) return;
      end
      tmo(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish by 200000");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_grants [5];
      bit          done;
      rst = 1; rdy = 1; flush = 0;
      if_req = 0; if_addr = 0; lsb_req = 0; lsb_wr = 0; lsb_addr = 0; lsb_wdata = 0;
      mc_done = 0; mc_rdata = 0;
      resp_en = 1; resp_lat = 2; man_done = 0; man_rdata = 0;
      repeat (3) step();
      chk1("rst_mc_valid", mc_valid, 1'b0);
      chk1("rst_if_ack", if_ack, 1'b0);
      chk1("rst_lsb_ack", lsb_ack, 1'b0);
      chk("rst_mc_addr", mc_addr, 32'h0);
      rst = 0;
      step();

      // Starvation: 4 fetches then the waiting load.
      grant_log.delete();
      if_req = 1; if_addr = 32'h100;
      lsb_req = 1; lsb_wr = 0; lsb_addr = 32'h1000; lsb_wdata = 32'h0;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         step();
         if (if_ack) if_addr = if_addr + 32'h4;
         if (lsb_ack) begin
            done = 1;
            lsb_req = 0; if_req = 0;
            chk("starve_lsb_rdata", lsb_rdata, 32'hDEADBEEF);
         end
      end
      if (!done) tmo("starve_lsb_ack");
      exp_grants = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h1000};
      chk("starve_grant_cnt", 32'(grant_log.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < grant_log.size()) chk($sformatf("starve_grant%0d", i), grant_log[i], exp_grants[i]);
      step(); step();

      // Store with flush two cycles into the grant: must still complete.
      resp_lat = 6;
      lsb_req = 1; lsb_wr = 1; lsb_addr = 32'h30000; lsb_wdata = 32'h41;
      wait_valid("st_grant");
      chk("st_wdata", mc_wdata, 32'h41);
      step(); step();
      flush = 1;
      step();
      flush = 0;
      chk1("st_flush_valid", mc_valid, 1'b1);
      chk1("st_flush_wr", mc_wr, 1'b1);
      wait_lsb_ack("st_ack");
      chk("st_rdata_kept", lsb_rdata, 32'hDEADBEEF);
      lsb_req = 0; lsb_wr = 0;
      step();
      chk1("st_ack_pulse", lsb_ack, 1'b0);

      // Fetch with flush coinciding with mc_done: discarded.
      resp_en = 0; man_done = 0; man_rdata = 32'h12345678;
      if_req = 1; if_addr = 32'h2000;
      wait_valid("fl_grant");
      step();
      man_done = 1; flush = 1;
      step();
      man_done = 0; flush = 0; if_req = 0;
      chk1("fl_valid", mc_valid, 1'b0);
      chk1("fl_if_ack", if_ack, 1'b0);
      chk("fl_if_rdata", if_rdata, 32'h5A00010C);
      step();
      chk1("fl_if_ack_late", if_ack, 1'b0);

      // rdy pause during a fetch grant.
      man_rdata = 32'hCAFEF00D;
      if_req = 1; if_addr = 32'h4000;
      wait_valid("rdy_grant");
      rdy = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rdy_addr", mc_addr, 32'h4000);
         chk1("rdy_valid", mc_valid, 1'b1);
         chk1("rdy_no_ack", if_ack, 1'b0);
      end
      rdy = 1;
      step();
      man_done = 1;
      step();
      man_done = 0;
      chk1("rdy_if_ack", if_ack, 1'b1);
      chk("rdy_if_rdata", if_rdata, 32'hCAFEF00D);
      if_req = 0;
      step();
      chk1("rdy_ack_pulse", if_ack, 1'b0);

      // Back-to-back loads.
      resp_en = 1; resp_lat = 2;
      lsb_req = 1; lsb_wr = 0; lsb_addr = 32'h5000;
      wait_lsb_ack("b2b_ack0");
      chk("b2b_rdata0", lsb_rdata, 32'h5A005000);
      chk1("b2b_gap", mc_valid, 1'b0);
      lsb_addr = 32'h5004;
      wait_lsb_ack("b2b_ack1");
      chk("b2b_rdata1", lsb_rdata, 32'h5A005004);
      lsb_req = 0;
      step();
      chk1("b2b_ack_pulse", lsb_ack, 1'b0);

      // Asynchronous reset in the middle of a load grant.
      resp_en = 0; man_done = 0;
      lsb_req = 1; lsb_addr = 32'h6000;
      wait_valid("rst_ld_grant");
      step();
      #2 rst = 1;
      #1;
      chk1("arst_valid", mc_valid, 1'b0);
      chk1("arst_lsb_ack", lsb_ack, 1'b0);
      chk1("arst_if_ack", if_ack, 1'b0);
      chk("arst_lsb_rdata", lsb_rdata, 32'h0);
      lsb_req = 0;
      @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("arst_no_ack", lsb_ack, 1'b0);
         chk1("arst_idle", mc_valid, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-owner scheduler in front of the byte-serial memory controller.
- Accepts word requests from the instruction fetch path (icache miss) and from the load/store buffer (LSB); grants exactly one at a time onto a unified downstream port.
- Holds the grant until completion and returns data/ack to the winner.
- Provides fetch-priority arbitration with a starvation bound for the LSB, plus flush (rollback) abort of speculative traffic.

Parameters:
STARVE_LIMIT, 4, consecutive fetch grants allowed while LSB is pending before the LSB is forced to win (1..15)
ADDR_W, 32, address width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global ready; 0 = pause, freeze all state
flush  in  1  rollback pulse; aborts speculative requests
if_req  in  1  fetch request, held until if_ack or flush
if_addr  in  ADDR_W  fetch word address
if_ack  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  32  fetched instruction word
lsb_req  in  1  LSB request, held until lsb_ack
lsb_wr  in  1  0 load, 1 store
lsb_addr  in  ADDR_W  LSB address
lsb_wdata  in  32  store data
lsb_ack  out  1  one-cycle pulse: load data valid / store done
lsb_rdata  out  32  load result
mc_valid  out  1  downstream request active; dropping it aborts the downstream transfer
mc_wr  out  1  downstream direction
mc_addr  out  ADDR_W  downstream address
mc_wdata  out  32  downstream store data
mc_done  in  1  downstream completion pulse
mc_rdata  in  32  downstream read data, valid with mc_done

Behaviour:
- Reset (async, rst=1): state IDLE; starve_cnt=0; all outputs 0.
- rdy=0: no state, counter or output register changes; mc_valid and mc_* hold their values; no acks generated.
- States: IDLE, GNT_IF, GNT_LD, GNT_ST.
- IDLE arbitration (registered; grant visible the next cycle):
  - lsb_req && (!if_req || starve_cnt==STARVE_LIMIT): go to GNT_ST if lsb_wr, else GNT_LD. Latch lsb_addr/lsb_wdata into mc_*. Clear starve_cnt.
  - else if_req: go to GNT_IF. Latch if_addr. Increment starve_cnt (saturating) if lsb_req, else clear it.
  - flush in IDLE suppresses any new fetch or load grant that cycle. A store may still be granted.
- GNT_*: mc_valid=1; mc_wr=1 only in GNT_ST; mc_addr/mc_wdata stable for the whole grant.
- mc_done in GNT_IF/GNT_LD/GNT_ST:
  - Next cycle: matching ack=1 for exactly one cycle; rdata register = mc_rdata (stores: lsb_rdata unchanged); state IDLE; mc_valid=0.
  - Rdata registers hold their value until the next ack.
- Minimum turnaround: one IDLE cycle between grants, so the downstream controller always observes mc_valid low and restarts at byte 0.
- Flush in GNT_IF or GNT_LD: next cycle mc_valid=0, state IDLE, no ack (including a same-cycle mc_done, which is discarded).
- Flush in GNT_ST: ignored. A granted store always completes.
- Requester drops its req mid-grant without flush: treated as an abort (IF/LD only); same behaviour as flush. A store keeps mc_valid until done.
- Simultaneous mc_done and a new request: the new request is arbitrated in the following IDLE cycle, never in the done cycle.
- starve_cnt saturates at STARVE_LIMIT; it is never cleared by flush.
- Latency, grant start to ack: downstream latency + 1 cycle. Request to mc_valid: 1 cycle from IDLE.

Decomposition:
- Shared defines: state encodings (ARB_IDLE/GNT_IF/GNT_LD/GNT_ST) and True/False in defines.v.
- One natural sub-module: arb_starve_counter, a saturating counter with inc/clr/limit compare, reusable for other arbiters.
- Grant FSM and datapath latches stay in mem_arbiter.

Test Plan:
- Reset mid-GNT_LD (rst asserted asynchronously) → mc_valid, lsb_ack, if_ack 0 immediately; state IDLE; no ack after release.
- if_req=1 continuously, lsb_req load at 0x1000 from cycle 0, STARVE_LIMIT=4 → exactly 4 fetch grants, then GNT_LD with mc_addr=0x1000, mc_wr=0; lsb_ack once with lsb_rdata=mc_rdata (e.g. 0xDEADBEEF).
- Store 0x30000 data 0x41, flush pulsed 2 cycles into grant → mc_valid held until mc_done; lsb_ack=1 one cycle later.
- GNT_IF with flush in the same cycle as mc_done → no if_ack; mc_valid=0 next cycle; if_rdata unchanged.
- rdy=0 for 5 cycles during GNT_IF, mc_done held off → mc_addr stable; no ack; completes normally after rdy=1.
- Back-to-back loads → mc_valid low for ≥1 cycle between grants; each lsb_ack a single-cycle pulse.
